// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer driving the shared 32-bit ALU.
// Shift-add multiply and restoring divide over 32 iterations, with a sign-fix cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_inA,
  output logic [31:0] alu_inB,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_r;
  logic            sign_a;
  logic            sign_b;
  logic            dz;
  logic [W-1:0]    acc;   // P_hi for multiply, remainder R for divide
  logic [W-1:0]    low;   // P_lo for multiply, quotient Q for divide
  logic [W-1:0]    mreg;  // multiplicand M or divisor D

  logic            is_mul;
  logic [W-1:0]    abs_a;
  logic [W-1:0]    abs_b;
  logic [W-1:0]    rs;
  logic            geq;
  logic            carry;
  logic [2*W-1:0]  prod_neg;

  assign is_mul   = ~op_r[1];
  assign abs_a    = (op[0] & opA[W-1]) ? W'(-opA) : opA;
  assign abs_b    = (op[0] & opB[W-1]) ? W'(-opB) : opB;
  assign rs       = {acc[W-2:0], low[W-1]};
  assign geq      = acc[W-1] | (rs >= mreg);
  // Carry out of P_hi + M recovered from operand and result MSBs
  assign carry    = (acc[W-1] & mreg[W-1]) | ((acc[W-1] | mreg[W-1]) & ~alu_result[W-1]);
  assign prod_neg = (2*W)'(-{acc, low});

  // ALU is only driven while iterating
  assign alu_inA  = (state == RUN) ? (is_mul ? acc : rs) : '0;
  assign alu_inB  = (state == RUN) ? mreg : '0;
  assign alu_fun  = (state == RUN && !is_mul) ? 6'b000001 : 6'b000000;
  assign alu_sign = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      low         <= '0;
      mreg        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            sign_a      <= op[0] & opA[W-1];
            sign_b      <= op[0] & opB[W-1];
            cnt         <= CW'(W - 1);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            if (op[1] && opB == '0) begin
              // Zero divisor: keep original dividend for hi, skip iteration
              dz    <= 1'b1;
              acc   <= opA;
              low   <= '0;
              mreg  <= '0;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              acc   <= '0;
              low   <= op[1] ? abs_a : abs_b;
              mreg  <= op[1] ? abs_b : abs_a;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (is_mul) begin
            if (low[0]) begin
              acc <= {carry, alu_result[W-1:1]};
              low <= {alu_result[0], low[W-1:1]};
            end else begin
              acc <= {1'b0, acc[W-1:1]};
              low <= {acc[0], low[W-1:1]};
            end
          end else begin
            acc <= geq ? alu_result : rs;
            low <= {low[W-2:0], geq};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (dz) begin
            div_by_zero <= 1'b1;
            hi          <= acc;
            lo          <= '1;
          end else if (is_mul) begin
            {hi, lo} <= (sign_a ^ sign_b) ? prod_neg : {acc, low};
          end else begin
            lo <= (sign_a ^ sign_b) ? W'(-low) : low;
            hi <= sign_a ? W'(-acc) : acc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops
// compared against a plain-arithmetic reference model; includes a behavioural ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_inA;
  logic [31:0] alu_inB;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Shared ALU: 000000 add, 000001 subtract
  assign alu_result = (alu_fun == 6'b000001) ? alu_inA - alu_inB : alu_inA + alu_inB;

  // Expected {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [63:0] ua;
    logic [63:0] ub;
    longint sa;
    longint sb;
    longint q;
    longint rm;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      2'b00: r = ua * ub;
      2'b01: r = 64'(sa * sb);
      2'b10: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          r = {a, 32'hFFFFFFFF};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"}, {busy, done, div_by_zero, hi, lo}, '0);
    chk({tag, "_alu"}, {alu_inA, alu_inB, alu_fun, alu_sign}, '0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (i == 0) chk("done_pulse_width", 64'(done), 64'd0);
    end
  endtask

  // Called at a negedge; presents start for one edge and waits for done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int glitch_at);
    logic [63:0] exp;
    int n;
    int lat;
    bit busy_ok;
    bit hold_ok;
    bit is_dz;
    exp   = model(o, a, b);
    is_dz = o[1] && (b == 0);
    lat   = is_dz ? 2 : 34;
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); opA = $urandom; opB = $urandom;
    n = 1;
    chk("dz_cleared_on_start", 64'(div_by_zero), 64'd0);
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== last_hi || lo !== last_lo) hold_ok = 1'b0;
      if (n == glitch_at) begin
        start = 1'b1; op = 2'($urandom); opA = $urandom; opB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", 64'(n), 64'(lat));
    chk("busy_while_active", 64'(busy_ok), 64'd1);
    chk("hilo_hold_while_active", 64'(hold_ok), 64'd1);
    chk("result_hi_lo", {hi, lo}, exp);
    chk("div_by_zero_flag", 64'(div_by_zero), 64'(is_dz));
    chk("busy_low_in_done", 64'(busy), 64'd0);
    chk("alu_idle_in_done", {alu_inA, alu_inB, alu_fun}, '0);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          no_done;

    reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    idle(2);
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0);
    idle(1);
    run_op(2'b01, 32'h80000000, 32'h80000000, 0);
    idle(1);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
    idle(1);
    run_op(2'b10, 32'd100, 32'd7, 0);
    idle(1);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    idle(1);
    run_op(2'b10, 32'd100, 32'd0, 0);
    idle(1);
    run_op(2'b00, 32'd12345, 32'd678, 0);
    idle(1);
    // start pulsed mid-run is ignored
    run_op(2'b01, 32'hDEADBEEF, 32'h01234567, 5);
    // back-to-back: second start lands in the done cycle
    run_op(2'b11, 32'h7FFFFFFF, 32'hFFFFFFF0, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'd3, 0);
    idle(1);

    // Reset in the middle of a divide
    start = 1'b1; op = 2'b11; opA = 32'hFFFFFC18; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_quiet("mid_run_reset");
    @(negedge clk);
    reset = 1'b0;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) no_done = 1'b0;
    end
    chk("no_done_after_abort", 64'(no_done), 64'd1);
    last_hi = '0;
    last_lo = '0;
    run_op(2'b11, 32'hFFFFFC18, 32'd7, 0);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
